param_reg_file: RTL and testbench

//  Parametrised register file: successor to the fixed 16-bit, single-register bitcell design.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/reg_word.sv | 17 +
 rtl/param_reg_file.sv | 96 +++++++++
 tb/tb_param_reg_file.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: clear-FSM state type and address-width helper for param_reg_file
package regfile_pkg;
  typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t;
  function automatic int rf_addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/reg_word.sv
// reg_word: one WIDTH-bit storage row with synchronous reset and load enable
module reg_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  // hold the stored word, load i_d when enabled
  always_ff @(posedge clk)
    if (rst) r_q <= '0;
    else if (i_we) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/param_reg_file.sv
// param_reg_file: DEPTH x WIDTH register file, 2 comb read ports, 1 write port, clear engine.
// Define RF_BYPASS_EN to forward an accepted same-cycle write onto the read ports.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] src_reg1,
  input  logic [$clog2(DEPTH)-1:0] src_reg2,
  output logic [WIDTH-1:0]         src_data1,
  output logic [WIDTH-1:0]         src_data2,
  input  logic [$clog2(DEPTH)-1:0] dst_reg,
  input  logic [WIDTH-1:0]         dst_data,
  input  logic                     write_reg,
  output logic                     wr_drop,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);
  localparam int AW = rf_addr_w(DEPTH);
  localparam bit ZR = (ZERO_REG != 0);
  rf_state_t        r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_clr_busy;
  logic             r_clr_done;
  logic             r_wr_drop;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_word [DEPTH];
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  // writes are only accepted while the clear engine is idle
  assign w_wr_ok = write_reg & ~r_clr_busy;
  // during the sweep every selected row loads zero
  assign w_d = r_clr_busy ? '0 : dst_data;
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic w_we;
    assign w_we = (w_wr_ok && dst_reg == AW'(i) && !(ZR && i == 0)) ||
                  (r_clr_busy && r_cnt == AW'(i));
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_we),
      .i_d  (w_d),
      .o_q  (w_word[i])
    );
  end
  assign w_rd1 = (ZR && src_reg1 == '0) ? '0 : w_word[src_reg1];
  assign w_rd2 = (ZR && src_reg2 == '0) ? '0 : w_word[src_reg2];
`ifdef RF_BYPASS_EN
  logic w_fwd_ok;
  assign w_fwd_ok  = w_wr_ok && !(ZR && dst_reg == '0);
  assign src_data1 = (w_fwd_ok && dst_reg == src_reg1) ? dst_data : w_rd1;
  assign src_data2 = (w_fwd_ok && dst_reg == src_reg2) ? dst_data : w_rd2;
`else
  assign src_data1 = w_rd1;
  assign src_data2 = w_rd2;
`endif
  // clear sequencer: sweep every row once, pulse done, flag writes lost to the sweep
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= RF_IDLE;
      r_cnt      <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_wr_drop <= write_reg & r_clr_busy;
      case (r_state)
        RF_IDLE:
          if (clr_req) begin
            r_state    <= RF_CLEAR;
            r_cnt      <= '0;
            r_clr_busy <= 1'b1;
          end
        RF_CLEAR:
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state    <= RF_DONE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
          end else r_cnt <= r_cnt + AW'(1);
        RF_DONE: begin
          r_state    <= RF_IDLE;
          r_clr_done <= 1'b0;
        end
        default: r_state <= RF_IDLE;
      endcase
    end
  assign wr_drop  = r_wr_drop;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: randomized and directed checks of param_reg_file against an array model
module tb_param_reg_file;
  localparam int W = 16, D = 16, AW = 4;
  localparam bit ZR = 1'b1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [AW-1:0] src_reg1 = '0, src_reg2 = '0, dst_reg = '0;
  logic [W-1:0] dst_data = '0;
  logic write_reg = 1'b0, clr_req = 1'b0;
  logic [W-1:0] src_data1, src_data2;
  logic wr_drop, clr_busy, clr_done;
  logic rst_w = 1'b1;
  logic [2:0] w_src1 = '0, w_src2 = '0, w_dst = '0;
  logic [31:0] w_dat = '0;
  logic w_we = 1'b0, w_clr = 1'b0;
  logic [31:0] w_q1, w_q2;
  logic w_drop, w_busy, w_done;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_mem [D];
  int m_pos = -1;
  bit m_done = 1'b0, m_drop = 1'b0;

  param_reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .src_data1(src_data1), .src_data2(src_data2), .dst_reg(dst_reg), .dst_data(dst_data),
    .write_reg(write_reg), .wr_drop(wr_drop), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done));

  param_reg_file #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0)) dut_w (
    .clk(clk), .rst(rst_w), .src_reg1(w_src1), .src_reg2(w_src2),
    .src_data1(w_q1), .src_data2(w_q2), .dst_reg(w_dst), .dst_data(w_dat),
    .write_reg(w_we), .wr_drop(w_drop), .clr_req(w_clr), .clr_busy(w_busy),
    .clr_done(w_done));

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = (ZR && a == 0) ? '0 : m_mem[a];
`ifdef RF_BYPASS_EN
    if (write_reg && m_pos < 0 && dst_reg == a && !(ZR && dst_reg == 0)) v = dst_data;
`endif
    return v;
  endfunction

  task automatic model_edge();
    bit busy, was_done;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_pos = -1; m_done = 1'b0; m_drop = 1'b0;
    end else begin
      busy = (m_pos >= 0);
      was_done = m_done;
      m_drop = write_reg && busy;
      m_done = 1'b0;
      if (write_reg && !busy && !(ZR && dst_reg == 0)) m_mem[dst_reg] = dst_data;
      if (busy) begin
        m_mem[m_pos] = '0;
        m_pos++;
        if (m_pos == D) begin m_pos = -1; m_done = 1'b1; end
      end else if (clr_req && !was_done) m_pos = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    for (int a = 0; a < D; a++) begin
      src_reg1 = AW'(a); src_reg2 = AW'(D - 1 - a); #1;
      n_cmp++; if (src_data1 !== '0) begin n_bad++; $display("FAIL reset_rd1 a=%0d got=%h exp=0", a, src_data1); end
      n_cmp++; if (src_data2 !== '0) begin n_bad++; $display("FAIL reset_rd2 a=%0d got=%h exp=0", a, src_data2); end
    end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop got=%b exp=0", wr_drop); end
    n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", clr_done); end
  endtask

  task automatic test_write_read();
    dst_reg = 4'd5; dst_data = 16'hBEEF; write_reg = 1'b1; step(); write_reg = 1'b0;
    src_reg1 = 4'd5; src_reg2 = 4'd5; #1;
    n_cmp++; if (src_data1 !== 16'hBEEF) begin n_bad++; $display("FAIL wr_r5_p1 got=%h exp=BEEF", src_data1); end
    n_cmp++; if (src_data2 !== 16'hBEEF) begin n_bad++; $display("FAIL wr_r5_p2 got=%h exp=BEEF", src_data2); end
    dst_reg = 4'd0; dst_data = 16'h1234; write_reg = 1'b1; step(); write_reg = 1'b0;
    src_reg1 = 4'd0; #1;
    n_cmp++; if (src_data1 !== 16'h0000) begin n_bad++; $display("FAIL wr_r0 got=%h exp=0000", src_data1); end
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL wr_r0_drop got=%b exp=0", wr_drop); end
    for (int c = 0; c < 60; c++) begin
      write_reg = 1'($urandom_range(0, 1)); dst_reg = AW'($urandom); dst_data = W'($urandom);
      src_reg1 = AW'($urandom); src_reg2 = (c % 3 == 0) ? dst_reg : AW'($urandom); #1;
      n_cmp++; if (src_data1 !== exp_rd(src_reg1)) begin n_bad++; $display("FAIL rnd_rd1 a=%0d got=%h exp=%h", src_reg1, src_data1, exp_rd(src_reg1)); end
      n_cmp++; if (src_data2 !== exp_rd(src_reg2)) begin n_bad++; $display("FAIL rnd_rd2 a=%0d got=%h exp=%h", src_reg2, src_data2, exp_rd(src_reg2)); end
      step();
      n_cmp++; if (wr_drop !== m_drop) begin n_bad++; $display("FAIL rnd_drop got=%b exp=%b", wr_drop, m_drop); end
    end
    write_reg = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cycles, done_cnt;
    busy_cycles = 0; done_cnt = 0;
    for (int a = 1; a < D; a++) begin
      dst_reg = AW'(a); dst_data = 16'hA5A5; write_reg = 1'b1; step();
    end
    write_reg = 1'b0; clr_req = 1'b1; step(); clr_req = 1'b0;
    for (int c = 0; c < D + 6; c++) begin
      if (clr_busy) busy_cycles++;
      if (clr_done) done_cnt++;
      write_reg = clr_busy && busy_cycles == 3;
      dst_reg = 4'd7; dst_data = 16'h1111;
      clr_req = (clr_busy && busy_cycles == 5) || clr_done;
      src_reg1 = AW'($urandom); src_reg2 = AW'(c); #1;
      n_cmp++; if (src_data1 !== exp_rd(src_reg1)) begin n_bad++; $display("FAIL clr_rd1 a=%0d got=%h exp=%h", src_reg1, src_data1, exp_rd(src_reg1)); end
      n_cmp++; if (src_data2 !== exp_rd(src_reg2)) begin n_bad++; $display("FAIL clr_rd2 a=%0d got=%h exp=%h", src_reg2, src_data2, exp_rd(src_reg2)); end
      step();
      n_cmp++; if (clr_busy !== (m_pos >= 0)) begin n_bad++; $display("FAIL clr_busy c=%0d got=%b exp=%b", c, clr_busy, m_pos >= 0); end
      n_cmp++; if (clr_done !== m_done) begin n_bad++; $display("FAIL clr_done c=%0d got=%b exp=%b", c, clr_done, m_done); end
      if (write_reg) begin
        n_cmp++; if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL clr_wr_drop got=%b exp=1", wr_drop); end
      end
      write_reg = 1'b0; clr_req = 1'b0;
    end
    n_cmp++; if (busy_cycles != D) begin n_bad++; $display("FAIL clr_len got=%0d exp=%0d", busy_cycles, D); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clr_done_cnt got=%0d exp=1", done_cnt); end
    for (int a = 0; a < D; a++) begin
      src_reg1 = AW'(a); src_reg2 = AW'(a); #1;
      n_cmp++; if (src_data1 !== '0) begin n_bad++; $display("FAIL clr_after a=%0d got=%h exp=0", a, src_data1); end
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp_same;
    dst_reg = 4'd3; dst_data = 16'h1357; write_reg = 1'b1; step();
    dst_data = 16'h00FF; src_reg1 = 4'd3; src_reg2 = 4'd0; #1;
`ifdef RF_BYPASS_EN
    exp_same = 16'h00FF;
`else
    exp_same = 16'h1357;
`endif
    n_cmp++; if (src_data1 !== exp_same) begin n_bad++; $display("FAIL byp_same got=%h exp=%h", src_data1, exp_same); end
    step(); write_reg = 1'b0; #1;
    n_cmp++; if (src_data1 !== 16'h00FF) begin n_bad++; $display("FAIL byp_next got=%h exp=00FF", src_data1); end
    dst_reg = 4'd0; dst_data = 16'hFFFF; write_reg = 1'b1; #1;
    n_cmp++; if (src_data2 !== '0) begin n_bad++; $display("FAIL byp_r0 got=%h exp=0", src_data2); end
    step(); write_reg = 1'b0;
  endtask

  task automatic test_rst_mid_clear();
    int done_seen;
    done_seen = 0;
    dst_reg = 4'd10; dst_data = 16'h5555; write_reg = 1'b1; step(); write_reg = 1'b0;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    step(); step(); step();
    n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL rmc_busy_pre got=%b exp=1", clr_busy); end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL rmc_busy got=%b exp=0", clr_busy); end
    for (int c = 0; c < 24; c++) begin
      if (clr_done) done_seen++;
      step();
    end
    n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL rmc_done got=%0d exp=0", done_seen); end
    src_reg1 = 4'd10; #1;
    n_cmp++; if (src_data1 !== '0) begin n_bad++; $display("FAIL rmc_r10 got=%h exp=0", src_data1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      write_reg = ($urandom_range(0, 1) == 1); dst_reg = AW'($urandom); dst_data = W'($urandom);
      clr_req = ($urandom_range(0, 40) == 0); rst = ($urandom_range(0, 150) == 0);
      src_reg1 = AW'($urandom); src_reg2 = (c % 4 == 0) ? dst_reg : AW'($urandom); #1;
      n_cmp++; if (src_data1 !== exp_rd(src_reg1)) begin n_bad++; $display("FAIL mix_rd1 c=%0d got=%h exp=%h", c, src_data1, exp_rd(src_reg1)); end
      n_cmp++; if (src_data2 !== exp_rd(src_reg2)) begin n_bad++; $display("FAIL mix_rd2 c=%0d got=%h exp=%h", c, src_data2, exp_rd(src_reg2)); end
      step();
      n_cmp++; if ({clr_busy, clr_done, wr_drop} !== {m_pos >= 0, m_done, m_drop}) begin
        n_bad++; $display("FAIL mix_flags c=%0d got=%b%b%b exp=%b%b%b", c, clr_busy, clr_done, wr_drop, m_pos >= 0, m_done, m_drop);
      end
    end
    write_reg = 1'b0; clr_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_wide();
    int busy_cycles;
    busy_cycles = 0;
    rst_w = 1'b1; step(); rst_w = 1'b0;
    w_dst = 3'd0; w_dat = 32'hDEADBEEF; w_we = 1'b1; step(); w_we = 1'b0;
    w_src1 = 3'd0; w_src2 = 3'd0; #1;
    n_cmp++; if (w_q1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wide_r0_p1 got=%h exp=DEADBEEF", w_q1); end
    n_cmp++; if (w_q2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wide_r0_p2 got=%h exp=DEADBEEF", w_q2); end
    w_clr = 1'b1; step(); w_clr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (w_busy) busy_cycles++;
      step();
    end
    n_cmp++; if (busy_cycles != 8) begin n_bad++; $display("FAIL wide_clr_len got=%0d exp=8", busy_cycles); end
    n_cmp++; if (w_q1 !== '0) begin n_bad++; $display("FAIL wide_after_clr got=%h exp=0", w_q1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear();
    test_bypass();
    test_rst_mid_clear();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
